// File: rtl/centroid_divider.sv
// Centroid divider: converts pixel-count / weighted sums into fixed-point
// x/y centroids using two parallel bit-serial restoring dividers, then runs
// the trigger/busy handshake back to the sum producer.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IDLE      | waiting for a trigger rise; operands latched on the rise
//   DIVIDE    | one quotient bit per cycle, MSB first, DW cycles
//   WAIT_TRIG | result published; waiting for the producer to drop trigger
//   HOLD      | oBUSY high for BUSY_HOLD cycles, then back to IDLE
module centroid_divider #(
    parameter int FRAC_BITS   = 4,
    parameter int COORD_WIDTH = 11,
    parameter int BUSY_HOLD   = 4
) (
    input  logic                             CCLK,
    input  logic                             RST_N,
    input  logic                             iSTART_TRIG,
    input  logic [19:0]                      iSUM_S,
    input  logic [27:0]                      iSUM_SX,
    input  logic [27:0]                      iSUM_SY,
    output logic                             oBUSY,
    output logic [COORD_WIDTH+FRAC_BITS-1:0] oCX,
    output logic [COORD_WIDTH+FRAC_BITS-1:0] oCY,
    output logic                             oVALID,
    output logic                             oNODATA,
    output logic [1:0]                       oSTATE
);

    localparam int DW  = 28 + FRAC_BITS;
    localparam int OW  = COORD_WIDTH + FRAC_BITS;
    localparam int SCW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DIVIDE    = 2'd1,
        WAIT_TRIG = 2'd2,
        HOLD      = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             trig_q;
    logic [SCW-1:0]   step_q, step_d;
    logic [7:0]       hold_q, hold_d;
    logic [19:0]      div_q, div_d;
    // Dividend shifts out of the MSB while quotient bits shift in at the LSB.
    logic [DW-1:0]    xq_q, xq_d, yq_q, yq_d;
    logic [19:0]      xr_q, xr_d, yr_q, yr_d;
    logic [OW-1:0]    cx_q, cx_d, cy_q, cy_d;
    logic             valid_q, valid_d;
    logic             nodata_q, nodata_d;
    logic             busy_q, busy_d;

    logic             rise;
    logic [20:0]      x_trial, y_trial;
    logic             x_ge, y_ge;
    logic [19:0]      x_diff, y_diff;
    logic [DW-1:0]    x_quo_nxt, y_quo_nxt;

    assign rise = iSTART_TRIG & ~trig_q;

    // One restoring-division step for each axis; the remainder after a
    // successful subtract is below the divisor, so 20 bits suffice.
    always_comb begin
        x_trial   = {xr_q, xq_q[DW-1]};
        y_trial   = {yr_q, yq_q[DW-1]};
        x_ge      = (x_trial >= {1'b0, div_q});
        y_ge      = (y_trial >= {1'b0, div_q});
        x_diff    = x_trial[19:0] - div_q;
        y_diff    = y_trial[19:0] - div_q;
        x_quo_nxt = {xq_q[DW-2:0], x_ge};
        y_quo_nxt = {yq_q[DW-2:0], y_ge};
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        hold_d   = hold_q;
        div_d    = div_q;
        xq_d     = xq_q;
        yq_d     = yq_q;
        xr_d     = xr_q;
        yr_d     = yr_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        nodata_d = nodata_q;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    div_d   = iSUM_S;
                    xq_d    = {iSUM_SX, {FRAC_BITS{1'b0}}};
                    yq_d    = {iSUM_SY, {FRAC_BITS{1'b0}}};
                    xr_d    = '0;
                    yr_d    = '0;
                    step_d  = SCW'(DW);
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                xq_d   = x_quo_nxt;
                yq_d   = y_quo_nxt;
                xr_d   = x_ge ? x_diff : x_trial[19:0];
                yr_d   = y_ge ? y_diff : y_trial[19:0];
                step_d = step_q - SCW'(1);
                if (step_q == SCW'(1)) begin
                    valid_d = 1'b1;
                    if (div_q == 20'd0) begin
                        cx_d     = '0;
                        cy_d     = '0;
                        nodata_d = 1'b1;
                    end else begin
                        cx_d     = (|x_quo_nxt[DW-1:OW]) ? {OW{1'b1}} : x_quo_nxt[OW-1:0];
                        cy_d     = (|y_quo_nxt[DW-1:OW]) ? {OW{1'b1}} : y_quo_nxt[OW-1:0];
                        nodata_d = 1'b0;
                    end
                    if (iSTART_TRIG) begin
                        state_d = WAIT_TRIG;
                    end else begin
                        state_d = HOLD;
                        hold_d  = 8'(BUSY_HOLD);
                    end
                end
            end
            WAIT_TRIG: begin
                if (!iSTART_TRIG) begin
                    state_d = HOLD;
                    hold_d  = 8'(BUSY_HOLD);
                end
            end
            HOLD: begin
                if (hold_q == 8'd1) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == HOLD);
    end

    // State, operand and result registers.
    always_ff @(posedge CCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            trig_q   <= 1'b0;
            step_q   <= '0;
            hold_q   <= '0;
            div_q    <= '0;
            xq_q     <= '0;
            yq_q     <= '0;
            xr_q     <= '0;
            yr_q     <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            valid_q  <= 1'b0;
            nodata_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            trig_q   <= iSTART_TRIG;
            step_q   <= step_d;
            hold_q   <= hold_d;
            div_q    <= div_d;
            xq_q     <= xq_d;
            yq_q     <= yq_d;
            xr_q     <= xr_d;
            yr_q     <= yr_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            valid_q  <= valid_d;
            nodata_q <= nodata_d;
            busy_q   <= busy_d;
        end
    end

    assign oBUSY   = busy_q;
    assign oCX     = cx_q;
    assign oCY     = cy_q;
    assign oVALID  = valid_q;
    assign oNODATA = nodata_q;
    assign oSTATE  = state_q;

endmodule

// File: tb/tb_centroid_divider.sv
// Testbench for centroid_divider: scoreboard of expected centroids pushed at
// trigger time and popped when oVALID fires.
module tb_centroid_divider;

    localparam int FB  = 4;
    localparam int OW  = 15;
    localparam int LAT = 33;
    localparam int BH  = 4;

    logic          CCLK;
    logic          RST_N;
    logic          iSTART_TRIG;
    logic [19:0]   iSUM_S;
    logic [27:0]   iSUM_SX;
    logic [27:0]   iSUM_SY;
    logic          oBUSY;
    logic [OW-1:0] oCX;
    logic [OW-1:0] oCY;
    logic          oVALID;
    logic          oNODATA;
    logic [1:0]    oSTATE;

    typedef struct packed {
        logic [OW-1:0] cx;
        logic [OW-1:0] cy;
        logic          nd;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total    = 0;

    centroid_divider #(.FRAC_BITS(4), .COORD_WIDTH(11), .BUSY_HOLD(4)) dut (
        .CCLK        (CCLK),
        .RST_N       (RST_N),
        .iSTART_TRIG (iSTART_TRIG),
        .iSUM_S      (iSUM_S),
        .iSUM_SX     (iSUM_SX),
        .iSUM_SY     (iSUM_SY),
        .oBUSY       (oBUSY),
        .oCX         (oCX),
        .oCY         (oCY),
        .oVALID      (oVALID),
        .oNODATA     (oNODATA),
        .oSTATE      (oSTATE)
    );

    initial CCLK = 1'b0;
    always #5 CCLK = ~CCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic exp_t model(input logic [19:0] s, input logic [27:0] sx,
                                   input logic [27:0] sy);
        exp_t        e;
        logic [63:0] qx;
        logic [63:0] qy;
        if (s == 20'd0) begin
            e.cx = '0;
            e.cy = '0;
            e.nd = 1'b1;
        end else begin
            qx   = ({36'd0, sx} << FB) / {44'd0, s};
            qy   = ({36'd0, sy} << FB) / {44'd0, s};
            e.cx = (qx > 64'h7FFF) ? 15'h7FFF : qx[OW-1:0];
            e.cy = (qy > 64'h7FFF) ? 15'h7FFF : qy[OW-1:0];
            e.nd = 1'b0;
        end
        return e;
    endfunction

    task automatic start_op(input logic [19:0] s, input logic [27:0] sx, input logic [27:0] sy);
        @(negedge CCLK);
        iSUM_S      = s;
        iSUM_SX     = sx;
        iSUM_SY     = sy;
        iSTART_TRIG = 1'b1;
        sb.push_back(model(s, sx, sy));
    endtask

    task automatic wait_result(input string name);
        int   n;
        bit   seen;
        exp_t e;
        seen = 1'b0;
        for (n = 1; n <= 60; n++) begin
            @(posedge CCLK);
            #1;
            if (oVALID) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen || n != LAT) $display("FAIL %s latency: got %0d cycles (seen=%0d) want %0d", name, n, seen, LAT);
        else pass_cnt++;
        total++;
        if (sb.size() == 0) begin
            $display("FAIL %s scoreboard: got empty queue want one entry", name);
            return;
        end
        pass_cnt++;
        e = sb.pop_front();
        total++;
        if (oCX !== e.cx) $display("FAIL %s cx: got %h want %h", name, oCX, e.cx);
        else pass_cnt++;
        total++;
        if (oCY !== e.cy) $display("FAIL %s cy: got %h want %h", name, oCY, e.cy);
        else pass_cnt++;
        total++;
        if (oNODATA !== e.nd) $display("FAIL %s nodata: got %b want %b", name, oNODATA, e.nd);
        else pass_cnt++;
        @(posedge CCLK);
        #1;
        total++;
        if (oVALID !== 1'b0 || oCX !== e.cx || oCY !== e.cy)
            $display("FAIL %s pulse/hold: got valid=%b cx=%h cy=%h want valid=0 cx=%h cy=%h",
                     name, oVALID, oCX, oCY, e.cx, e.cy);
        else pass_cnt++;
    endtask

    task automatic test_handshake(input string name);
        int first_k;
        int hi;
        first_k = 0;
        hi      = 0;
        @(negedge CCLK);
        iSTART_TRIG = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge CCLK);
            #1;
            if (oBUSY) begin
                hi++;
                if (first_k == 0) first_k = k;
            end
        end
        total++;
        if (first_k != 1) $display("FAIL %s busy rise: got cycle %0d want 1", name, first_k);
        else pass_cnt++;
        total++;
        if (hi != BH) $display("FAIL %s busy length: got %0d want %0d", name, hi, BH);
        else pass_cnt++;
        total++;
        if (oSTATE !== 2'd0) $display("FAIL %s end state: got %0d want 0", name, oSTATE);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        RST_N       = 1'b0;
        iSTART_TRIG = 1'b0;
        iSUM_S      = '0;
        iSUM_SX     = '0;
        iSUM_SY     = '0;
        repeat (3) @(negedge CCLK);
        total++;
        if ({oBUSY, oVALID, oNODATA, oCX, oCY, oSTATE} !== '0)
            $display("FAIL reset outputs: got busy=%b valid=%b nd=%b cx=%h cy=%h st=%0d want all 0",
                     oBUSY, oVALID, oNODATA, oCX, oCY, oSTATE);
        else pass_cnt++;
        RST_N = 1'b1;
        repeat (2) @(negedge CCLK);
    endtask

    task automatic test_op(input string name, input logic [19:0] s, input logic [27:0] sx,
                           input logic [27:0] sy);
        start_op(s, sx, sy);
        wait_result(name);
        test_handshake(name);
    endtask

    task automatic test_random();
        logic [19:0] s;
        logic [27:0] sx;
        logic [27:0] sy;
        for (int i = 0; i < 3; i++) begin
            s  = 20'($urandom_range(1, 1048575));
            sx = 28'($urandom);
            sy = 28'($urandom_range(0, 2000000));
            test_op("random", s, sx, sy);
        end
    endtask

    task automatic test_back_to_back();
        int   vcnt;
        int   first_n;
        bit   busy_seen;
        exp_t e;
        vcnt      = 0;
        first_n   = 0;
        busy_seen = 1'b0;
        start_op(20'd7, 28'd12345, 28'd54321);
        for (int n = 1; n <= 512; n++) begin
            @(posedge CCLK);
            #1;
            if (oBUSY) busy_seen = 1'b1;
            if (oVALID) begin
                vcnt++;
                if (first_n == 0) begin
                    first_n = n;
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        total++;
                        if (oCX !== e.cx || oCY !== e.cy)
                            $display("FAIL b2b data: got cx=%h cy=%h want cx=%h cy=%h", oCX, oCY, e.cx, e.cy);
                        else pass_cnt++;
                    end
                end
            end
            if (n == 5) iSTART_TRIG = 1'b0;
            if (n == 6) iSTART_TRIG = 1'b1;
        end
        total++;
        if (vcnt != 1) $display("FAIL b2b valid count: got %0d want 1", vcnt);
        else pass_cnt++;
        total++;
        if (first_n != LAT) $display("FAIL b2b latency: got %0d want %0d", first_n, LAT);
        else pass_cnt++;
        total++;
        if (busy_seen || oSTATE !== 2'd2)
            $display("FAIL b2b wait: got busy_seen=%b state=%0d want 0 and 2", busy_seen, oSTATE);
        else pass_cnt++;
        test_handshake("b2b");
    endtask

    task automatic test_reset_mid_divide();
        @(negedge CCLK);
        iSUM_S      = 20'd9;
        iSUM_SX     = 28'd4000;
        iSUM_SY     = 28'd777;
        iSTART_TRIG = 1'b1;
        repeat (10) @(posedge CCLK);
        #1;
        total++;
        if (oSTATE !== 2'd1) $display("FAIL rst_mid state: got %0d want 1", oSTATE);
        else pass_cnt++;
        RST_N = 1'b0;
        #1;
        total++;
        if ({oBUSY, oVALID, oNODATA, oCX, oCY, oSTATE} !== '0)
            $display("FAIL rst_mid outputs: got busy=%b valid=%b nd=%b cx=%h cy=%h st=%0d want all 0",
                     oBUSY, oVALID, oNODATA, oCX, oCY, oSTATE);
        else pass_cnt++;
        @(negedge CCLK);
        // Trigger still high at release: the first clock sees it as a fresh rise.
        RST_N = 1'b1;
        sb.push_back(model(20'd9, 28'd4000, 28'd777));
        wait_result("rst_restart");
        test_handshake("rst_restart");
    endtask

    initial begin
        test_reset();
        test_op("basic", 20'd100, 28'd32000, 28'd24000);
        test_op("truncate", 20'd3, 28'd1000, 28'd2);
        test_op("nodata", 20'd0, 28'd1234, 28'd5678);
        test_op("saturate", 20'd1, 28'hFFFFFFF, 28'd5);
        test_random();
        test_back_to_back();
        test_reset_mid_divide();
        test_op("after", 20'd100, 28'd32000, 28'd24000);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
